// File: rtl/shift_seq_pkg.sv
// Shared types for the shift-register sequencer: FSM states and the
// {s1,s0} mode encoding of the 4-bit universal shift register.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Sequencer that parallel-loads words into the universal shift register and
// streams the exiting tap out as a flow-controlled serial bit stream.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_fill,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] par_data,
    output logic             msb_in,
    output logic             lsb_in,
    input  logic             msb_tap,
    input  logic             lsb_tap,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshakes: a beat transfers on a rising edge where valid && ready;
    // valid never waits on ready and its payload stays stable until taken.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

    state_t           r_state;
    logic [WIDTH-1:0] r_word;
    logic             r_dir;
    logic             r_fill;
    logic [CW-1:0]    r_bit_cnt;
    logic [GW-1:0]    r_gap_cnt;

    logic             w_accept;
    logic             w_shift;
    logic             w_xfer;
    logic             w_last;
    logic [1:0]       w_mode;

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_shift   = (r_state == ST_SHIFT);
    assign w_xfer    = w_shift && ser_ready;
    assign w_last    = (r_bit_cnt == CNT_LAST);

    assign ser_valid = w_shift;
    assign ser_bit   = w_shift && (r_dir ? msb_tap : lsb_tap);
    assign ser_last  = w_shift && w_last;
    // A word cut short by reset must never report completion.
    assign done      = w_xfer && w_last && !rst;

    assign par_data  = r_word;
    assign msb_in    = r_fill;
    assign lsb_in    = r_fill;
    assign {s1, s0}  = w_mode;
    assign dbg_state = r_state;

    always_comb begin
        w_mode = MODE_HOLD;
        case (r_state)
            ST_LOAD:  w_mode = MODE_LOAD;
            ST_SHIFT: w_mode = ser_ready ? (r_dir ? MODE_SHL : MODE_SHR) : MODE_HOLD;
            default:  w_mode = MODE_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_word    <= '0;
            r_dir     <= 1'b0;
            r_fill    <= 1'b0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_word  <= in_data;
                        r_dir   <= in_dir;
                        r_fill  <= in_fill;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_bit_cnt <= '0;
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_bit_cnt <= '0;
                            r_gap_cnt <= '0;
                            r_state   <= (GAP > 0) ? ST_GAP : ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl looped through a behavioural 4-bit universal
// shift register; expected serial streams come from the accepted words.
module tb_shift_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int GAP   = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_dir = 1'b0;
    logic             in_fill = 1'b0;
    logic             ser_ready = 1'b1;
    logic             in_ready, s1, s0, msb_in, lsb_in, msb_tap, lsb_tap;
    logic             ser_valid, ser_bit, ser_last, done;
    logic [WIDTH-1:0] par_data;
    logic [1:0]       dbg_state;

    logic [WIDTH-1:0] sr;

    shift_seq_ctrl #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dir(in_dir), .in_fill(in_fill),
        .s1(s1), .s0(s0), .par_data(par_data),
        .msb_in(msb_in), .lsb_in(lsb_in), .msb_tap(msb_tap), .lsb_tap(lsb_tap),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_bit(ser_bit),
        .ser_last(ser_last), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // External universal shift register sharing rst with the sequencer.
    assign msb_tap = sr[WIDTH-1];
    assign lsb_tap = sr[0];
    always @(posedge clk) begin
        if (rst) sr <= '0;
        else begin
            case ({s1, s0})
                2'b01:   sr <= {msb_in, sr[WIDTH-1:1]};
                2'b10:   sr <= {sr[WIDTH-2:0], lsb_in};
                2'b11:   sr <= par_data;
                default: sr <= sr;
            endcase
        end
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Scoreboard state: expected {last,bit} beats and {dir,fill} of words in flight.
    logic [1:0]       exp_q[$];
    logic [1:0]       word_q[$];
    int               acc_cyc[$];
    int               bits_done = 0;
    int               dones = 0;
    int               ld_stage = 0;
    logic [WIDTH-1:0] ld_word = '0;
    logic             chk_reg = 1'b0;
    logic [WIDTH-1:0] reg_exp = '0;
    logic             prev_stall = 1'b0;
    logic             prev_bit = 1'b0;
    logic             prev_last = 1'b0;

    initial begin
        logic [1:0]       e;
        logic             dir;
        logic [WIDTH-1:0] d;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("in_ready_in_rst", in_ready, 0);
                check("done_in_rst", done, 0);
                exp_q.delete();
                word_q.delete();
                bits_done  = 0;
                ld_stage   = 0;
                chk_reg    = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (chk_reg) begin
                    check("reg_after_word", sr, reg_exp);
                    chk_reg = 1'b0;
                end
                if (ld_stage == 1) begin
                    check("load_mode", {s1, s0}, 2'b11);
                    check("load_par_data", par_data, ld_word);
                    check("load_no_valid", ser_valid, 0);
                    ld_stage = 2;
                end else if (ld_stage == 2) begin
                    check("first_valid_latency", ser_valid, 1);
                    ld_stage = 0;
                end
                if (in_ready) begin
                    check("idle_mode", {s1, s0}, 2'b00);
                    check("idle_no_valid", ser_valid, 0);
                end
                if (prev_stall) begin
                    check("stall_bit_stable", ser_bit, prev_bit);
                    check("stall_last_stable", ser_last, prev_last);
                end
                if (ser_valid) begin
                    check("valid_has_word", word_q.size() > 0, 1);
                    dir = (word_q.size() > 0) ? word_q[0][1] : 1'b0;
                    if (ser_ready) begin
                        check("shift_mode", {s1, s0}, dir ? 2'b10 : 2'b01);
                        check("xfer_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("ser_bit", ser_bit, e[0]);
                            check("ser_last", ser_last, e[1]);
                            check("done_on_last", done, e[1]);
                            if (done) dones++;
                            bits_done++;
                            if (e[1] && word_q.size() > 0) begin
                                reg_exp   = {WIDTH{word_q[0][0]}};
                                void'(word_q.pop_front());
                                chk_reg   = 1'b1;
                                bits_done = 0;
                            end
                        end
                    end else begin
                        check("stall_mode", {s1, s0}, 2'b00);
                        check("stall_no_done", done, 0);
                    end
                end else begin
                    check("idle_ser_bit", ser_bit, 0);
                    check("idle_ser_last", ser_last, 0);
                    check("idle_no_done", done, 0);
                end
                prev_stall = ser_valid && !ser_ready;
                prev_bit   = ser_bit;
                prev_last  = ser_last;
                if (in_valid && in_ready) begin
                    d = in_data;
                    for (int i = 0; i < WIDTH; i++)
                        exp_q.push_back({i == WIDTH - 1, in_dir ? d[WIDTH-1-i] : d[i]});
                    word_q.push_back({in_dir, in_fill});
                    acc_cyc.push_back(cycle);
                    ld_stage = 1;
                    ld_word  = d;
                end
            end
        end
    end

    // Serial-side ready driver: scripted stalls take priority over random backpressure.
    int   stall_n = 0;
    logic rand_ready = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_n > 0) begin
                ser_ready = 1'b0;
                stall_n--;
            end else begin
                ser_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic wait_accept();
        logic got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        check("accept_timeout", got, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, input logic dir, input logic fill);
        in_data  = d;
        in_dir   = dir;
        in_fill  = fill;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        logic ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && word_q.size() == 0 && in_ready && !chk_reg) ok = 1'b1;
        end
        check("drain_timeout", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bits(input int k);
        logic ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (ser_valid && bits_done == k) ok = 1'b1;
        end
        check("bit_wait_timeout", ok, 1);
    endtask

    initial begin
        int d0;
        int n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_ser_valid", ser_valid, 0);
        check("rst_mode", {s1, s0}, 2'b00);
        check("rst_par_data", par_data, 0);
        check("rst_done", done, 0);
        check("rst_register", sr, 0);
        @(posedge clk);
        #1;

        // LSB-first, fill 0, then MSB-first, fill 1.
        d0 = dones;
        send_word(4'b1011, 1'b0, 1'b0);
        wait_drain();
        check("lsb_first_done_count", dones - d0, 1);
        d0 = dones;
        send_word(4'b1011, 1'b1, 1'b1);
        wait_drain();
        check("msb_first_done_count", dones - d0, 1);

        // Three stall cycles on the third bit.
        d0 = dones;
        send_word(4'b0110, 1'b0, 1'b1);
        wait_bits(1);
        stall_n = 3;
        wait_drain();
        check("stall_done_count", dones - d0, 1);

        // in_valid held high across two words: minimum accept spacing.
        in_data  = 4'b1100;
        in_dir   = 1'b1;
        in_fill  = 1'b0;
        in_valid = 1'b1;
        wait_accept();
        in_data  = 4'b0101;
        in_dir   = 1'b0;
        in_fill  = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        n = acc_cyc.size();
        check("accept_spacing", acc_cyc[n-1] - acc_cyc[n-2], WIDTH + GAP + 2);
        wait_drain();

        // Reset while the third bit is on the wire.
        send_word(4'b1001, 1'b0, 1'b1);
        wait_bits(1);
        d0 = dones;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_mode", {s1, s0}, 2'b00);
        check("midrst_ser_valid", ser_valid, 0);
        check("midrst_register", sr, 0);
        check("midrst_no_done", dones - d0, 0);
        @(posedge clk);
        #1;

        // Random words under random backpressure.
        rand_ready = 1'b1;
        d0 = dones;
        for (int i = 0; i < 20; i++)
            send_word(WIDTH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        wait_drain();
        check("random_done_count", dones - d0, 20);
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
